uart_rx_controller: RTL and testbench

//  Frame-level sequencer for the UART receive path. Synchronises raw rx and detects the start edge.

---
 rtl/uart_rx_controller.sv | 198 +++++++++++++++++++
 tb/tb_uart_rx_controller.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_controller.sv
// UART receive frame sequencer: rx synchroniser, start detect, bit shift and valid/ack holding register.
// Optional parity stage is built when UART_RX_PARITY_EN is defined.
module uart_rx_controller #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx,
  input  logic                 sampling_strobe,
  output logic                 start_detected,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_valid,
  input  logic                 data_ack,
  output logic                 framing_error,
  output logic                 overrun_error,
  output logic                 parity_error,
  output logic                 busy
);

  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  if (DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_rx_controller: bad DATA_BITS/PARITY_ODD");
  end

  logic meta_q, rx_s_q, rx_prev_q;
  logic fall;

  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 start_q, start_d;
  logic                 ferr_q, ferr_d;
  logic                 oerr_q, oerr_d;
  logic                 commit;

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  logic perr_q, perr_d;
  logic exp_par;

  assign exp_par = (^shift_q) ^ PARITY_ODD[0];
`endif

  // Falling edge seen on the synchronised line
  assign fall = rx_prev_q & ~rx_s_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q    <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      meta_q    <= rx;
      rx_s_q    <= meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    start_d = 1'b0;
    ferr_d  = 1'b0;
    commit  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (fall) begin
          start_d = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (sampling_strobe) begin
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            cnt_d   = '0;
          end
        end
      end
      S_DATA: begin
        if (sampling_strobe) begin
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (sampling_strobe) begin
          par_d   = rx_s_q ^ exp_par;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (sampling_strobe) begin
          state_d = S_IDLE;
          // Framing beats parity beats overrun
          if (!rx_s_q) ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          else if (par_q) perr_d = 1'b1;
`endif
          else commit = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    oerr_d  = 1'b0;
    if (commit) begin
      if (!valid_q || data_ack) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        oerr_d = 1'b1;
      end
    end else if (data_ack) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
      ferr_q  <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      start_q <= start_d;
      ferr_q  <= ferr_d;
      oerr_q  <= oerr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end

  assign parity_error = perr_q;
`else
  assign parity_error = 1'b0;
`endif

  assign start_detected = start_q;
  assign rx_data        = data_q;
  assign data_valid     = valid_q;
  assign framing_error  = ferr_q;
  assign overrun_error  = oerr_q;
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_controller.sv
// Randomised frame-level bench for uart_rx_controller with an in-bench
// strobe source (8 clocks per bit) and a transaction-level reference model.
module tb_uart_rx_controller;

  localparam int CPB = 8;

  logic       clk;
  logic       reset_n;
  logic       rx;
  logic       sampling_strobe;
  logic       start_detected;
  logic [7:0] rx_data;
  logic       data_valid;
  logic       data_ack;
  logic       framing_error;
  logic       overrun_error;
  logic       parity_error;
  logic       busy;

  uart_rx_controller #(
    .DATA_BITS (8),
    .PARITY_ODD(0)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .rx             (rx),
    .sampling_strobe(sampling_strobe),
    .start_detected (start_detected),
    .rx_data        (rx_data),
    .data_valid     (data_valid),
    .data_ack       (data_ack),
    .framing_error  (framing_error),
    .overrun_error  (overrun_error),
    .parity_error   (parity_error),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe source: restarted by start_detected, one pulse per bit period
  int scnt;
  always @(posedge clk) begin
    if (start_detected || !busy) begin
      scnt            <= 0;
      sampling_strobe <= 1'b0;
    end else if (scnt == 0) begin
      scnt            <= CPB - 1;
      sampling_strobe <= 1'b1;
    end else begin
      scnt            <= scnt - 1;
      sampling_strobe <= 1'b0;
    end
  end

  int n_start, n_ferr, n_oerr, n_perr;
  always @(negedge clk) begin
    if (start_detected) n_start <= n_start + 1;
    if (framing_error)  n_ferr  <= n_ferr + 1;
    if (overrun_error)  n_oerr  <= n_oerr + 1;
    if (parity_error)   n_perr  <= n_perr + 1;
  end

  int n_chk;
  int n_fail;

  logic       m_valid;
  logic [7:0] m_data;
  int         e_start, e_ferr, e_oerr, e_perr;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx       = 1'b1;
      data_ack = 1'b0;
    end
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    m_valid  = 1'b0;
  endtask

  task automatic frame_check(input string tag);
    check({tag, ".valid"}, int'(data_valid), int'(m_valid));
    check({tag, ".data"},  int'(rx_data),    int'(m_data));
    check({tag, ".start"}, n_start, e_start);
    check({tag, ".ferr"},  n_ferr,  e_ferr);
    check({tag, ".oerr"},  n_oerr,  e_oerr);
    check({tag, ".perr"},  n_perr,  e_perr);
    check({tag, ".busy"},  int'(busy), 0);
  endtask

  // Drives one frame; ack_c raises data_ack on the stop-bit strobe cycle
  task automatic send(input logic [7:0] d, input logic stop_b,
                      input logic bad_par, input logic ack_c);
    logic bits[$];
    logic seen;
    logic done;
    logic commit;
    int   last;
    commit = stop_b && !bad_par;
    if (!stop_b) e_ferr++;
    else if (bad_par) e_perr++;
    else if (!m_valid || ack_c) begin
      m_data  = d;
      m_valid = 1'b1;
    end else e_oerr++;
    if (!commit && ack_c) m_valid = 1'b0;
    e_start++;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef UART_RX_PARITY_EN
    bits.push_back((^d) ^ bad_par);
`endif
    bits.push_back(stop_b);
    last = bits.size() - 1;
    seen = 1'b0;
    done = 1'b0;
    for (int b = 0; b <= last; b++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        rx       = bits[b];
        data_ack = 1'b0;
        if (b == last) begin
          if (seen && !done) begin
            done = 1'b1;
            check("lat.valid", int'(data_valid), int'(m_valid));
            check("lat.data",  int'(rx_data),    int'(m_data));
            check("lat.ferr",  int'(framing_error), int'(!stop_b));
          end
          if (sampling_strobe && !seen) begin
            seen     = 1'b1;
            data_ack = ack_c;
          end
        end
      end
    end
    @(negedge clk);
    data_ack = 1'b0;
    check("stop_strobe_seen", int'(done), 1);
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    m_valid  = 1'b0;
    m_data   = 8'h00;
    e_start  = 0;
    e_ferr   = 0;
    e_oerr   = 0;
    e_perr   = 0;
    n_start  = 0;
    n_ferr   = 0;
    n_oerr   = 0;
    n_perr   = 0;
    rx       = 1'b1;
    data_ack = 1'b0;
    reset_n  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.valid", int'(data_valid), 0);
    check("rst.data",  int'(rx_data), 0);
    check("rst.busy",  int'(busy), 0);
    check("rst.start", int'(start_detected), 0);
    check("rst.errs",  int'({framing_error, overrun_error, parity_error}), 0);
    reset_n = 1'b1;
    idle(10);

    send(8'hA5, 1'b1, 1'b0, 1'b0);
    idle(6);
    frame_check("t1");
    ack_pulse();
    idle(2);
    check("t1.ack", int'(data_valid), 0);

    repeat (3) begin
      @(negedge clk);
      rx = 1'b0;
    end
    e_start++;
    idle(30);
    frame_check("t2");

    send(8'h3C, 1'b0, 1'b0, 1'b0);
    idle(6);
    frame_check("t3a");
    send(8'h81, 1'b1, 1'b0, 1'b0);
    idle(6);
    frame_check("t3b");
    ack_pulse();

    send(8'h11, 1'b1, 1'b0, 1'b0);
    idle(4);
    send(8'h22, 1'b1, 1'b0, 1'b0);
    idle(4);
    frame_check("t4a");
    send(8'h22, 1'b1, 1'b0, 1'b1);
    idle(4);
    frame_check("t4b");
    ack_pulse();

    send(8'h00, 1'b0, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    check("brk.start", n_start, e_start);
    idle(10);
    frame_check("brk");

    send(8'h66, 1'b1, 1'b0, 1'b0);
    idle(4);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    e_start++;
    reset_n = 1'b0;
    #1;
    m_valid = 1'b0;
    m_data  = 8'h00;
    check("t5.valid", int'(data_valid), 0);
    check("t5.data",  int'(rx_data), 0);
    check("t5.busy",  int'(busy), 0);
    check("t5.pulses", int'({start_detected, framing_error,
                             overrun_error, parity_error}), 0);
    idle(4);
    reset_n = 1'b1;
    idle(10);
    send(8'h5A, 1'b1, 1'b0, 1'b0);
    idle(6);
    frame_check("t5");

`ifdef UART_RX_PARITY_EN
    ack_pulse();
    send(8'h07, 1'b1, 1'b0, 1'b0);
    idle(6);
    frame_check("t6a");
    ack_pulse();
    send(8'h07, 1'b1, 1'b1, 1'b0);
    idle(6);
    frame_check("t6b");
`endif

    for (int k = 0; k < 40; k++) begin
      logic [7:0] d;
      logic       sb;
      logic       bp;
      logic       ac;
      d  = 8'($urandom);
      sb = ($urandom_range(0, 5) != 0);
      ac = ($urandom_range(0, 2) == 0);
`ifdef UART_RX_PARITY_EN
      bp = ($urandom_range(0, 4) == 0);
`else
      bp = 1'b0;
`endif
      send(d, sb, bp, ac);
      idle(int'($urandom_range(3, 8)));
      frame_check("rnd");
      if ($urandom_range(0, 1) == 1) ack_pulse();
    end

    idle(4);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
